// File: rtl/bp_fe_bp_ghist.sv
// Global-history branch direction predictor: speculative GHR, gshare/gselect hash, saturating counters.
// Optional macro BP_FE_BP_GHIST_BYPASS_EN forwards a same-cycle write to a colliding read.
module bp_fe_bp_ghist #(
    parameter int bht_idx_width_p   = 9,
    parameter int bp_cnt_sat_bits_p = 2,
    parameter int ghist_width_p     = 8,
    parameter int hash_mode_p       = 0
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    output logic                       init_done_o,
    input  logic                       r_v_i,
    input  logic [bht_idx_width_p-1:0] idx_r_i,
    output logic                       predict_v_o,
    output logic                       predict_o,
    output logic [ghist_width_p-1:0]   ghist_o,
    input  logic                       w_v_i,
    input  logic [bht_idx_width_p-1:0] idx_w_i,
    input  logic [ghist_width_p-1:0]   ghist_w_i,
    input  logic                       taken_i,
    input  logic                       mispredict_i
);

    localparam int N = bht_idx_width_p;
    localparam int C = bp_cnt_sat_bits_p;
    localparam int W = ghist_width_p;
    localparam int entries_lp = 1 << N;
    localparam logic [N-1:0] last_lp = N'(entries_lp - 1);
    localparam logic [C-1:0] weak_nt_lp = C'((1 << (C - 1)) - 1);
    localparam logic [C-1:0] cnt_max_lp = '1;
    // Low idx bits kept by gselect below the history field.
    localparam logic [N-1:0] sel_mask_lp = N'((64'd1 << (N - W)) - 64'd1);

    typedef enum logic {INIT, READY} state_e;

    state_e         state_q, state_n;
    logic [N-1:0]   ptr_q;
    logic [W-1:0]   ghr_q;
    logic           pv_q, p_q;
    logic [W-1:0]   gh_q;
    logic [C-1:0]   mem [entries_lp];

    logic           ready;
    logic           write_en;
    logic           repair;
    logic [N-1:0]   hash_r, hash_w;
    logic [C-1:0]   cnt_w_old, cnt_w_new, cnt_r;

    function automatic logic [N-1:0] hash(input logic [N-1:0] idx,
                                          input logic [W-1:0] gh);
        if (hash_mode_p == 0)
            return idx ^ N'(gh);
        else
            return (N'(gh) << (N - W)) | (idx & sel_mask_lp);
    endfunction

    assign ready     = (state_q == READY);
    assign write_en  = ready & w_v_i;
    assign repair    = write_en & mispredict_i;
    assign hash_r    = hash(idx_r_i, ghr_q);
    assign hash_w    = hash(idx_w_i, ghist_w_i);
    assign cnt_w_old = mem[hash_w];

    // Saturating step of the resolved counter toward the actual direction.
    always_comb begin
        cnt_w_new = cnt_w_old;
        if (taken_i && cnt_w_old != cnt_max_lp)
            cnt_w_new = cnt_w_old + C'(1);
        else if (!taken_i && cnt_w_old != '0)
            cnt_w_new = cnt_w_old - C'(1);
    end

    // Read data, optionally forwarding a colliding same-cycle update.
    always_comb begin
        cnt_r = mem[hash_r];
`ifdef BP_FE_BP_GHIST_BYPASS_EN
        if (write_en && hash_w == hash_r)
            cnt_r = cnt_w_new;
`endif
    end

    // Next-state: leave INIT after the last table entry is swept.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            INIT:    if (ptr_q == last_lp) state_n = READY;
            READY:   state_n = READY;
            default: state_n = INIT;
        endcase
    end

    // State register and sweep pointer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_n;
            if (state_q == INIT)
                ptr_q <= ptr_q + N'(1);
        end
    end

    // Counter table: init sweep writes weakly-not-taken, then resolution updates.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            if (state_q == INIT)
                mem[ptr_q] <= weak_nt_lp;
            else if (write_en)
                mem[hash_w] <= cnt_w_new;
        end
    end

    // Global history: repair wins over the speculative shift.
    always_ff @(posedge clk_i) begin
        if (reset_i)
            ghr_q <= '0;
        else if (repair)
            ghr_q <= W'({ghist_w_i, taken_i});
        else if (ready && pv_q)
            ghr_q <= W'({ghr_q, p_q});
    end

    // Registered prediction; a same-cycle repair squashes the request.
    always_ff @(posedge clk_i) begin
        if (reset_i || !ready) begin
            pv_q <= 1'b0;
            p_q  <= 1'b0;
            gh_q <= '0;
        end else begin
            pv_q <= r_v_i & ~repair;
            p_q  <= r_v_i & cnt_r[C-1];
            gh_q <= r_v_i ? ghr_q : '0;
        end
    end

    assign init_done_o = ready;
    assign predict_v_o = pv_q;
    assign predict_o   = p_q;
    assign ghist_o     = gh_q;

endmodule

// File: tb/tb_bp_fe_bp_ghist.sv
// Randomised self-checking bench for bp_fe_bp_ghist (16-entry table, 4-bit history, gshare).
// Scenario tasks compare the DUT against a behavioural table/history model.
module tb_bp_fe_bp_ghist;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       init_done_o;
    logic       r_v_i;
    logic [3:0] idx_r_i;
    logic       predict_v_o;
    logic       predict_o;
    logic [3:0] ghist_o;
    logic       w_v_i;
    logic [3:0] idx_w_i;
    logic [3:0] ghist_w_i;
    logic       taken_i;
    logic       mispredict_i;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    int m_cnt [16];
    int m_sweep;
    bit m_ready;
    int m_ghr;
    bit m_pv;
    bit m_p;
    int m_gh;

    bp_fe_bp_ghist #(
        .bht_idx_width_p(4),
        .bp_cnt_sat_bits_p(2),
        .ghist_width_p(4),
        .hash_mode_p(0)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .init_done_o(init_done_o),
        .r_v_i(r_v_i),
        .idx_r_i(idx_r_i),
        .predict_v_o(predict_v_o),
        .predict_o(predict_o),
        .ghist_o(ghist_o),
        .w_v_i(w_v_i),
        .idx_w_i(idx_w_i),
        .ghist_w_i(ghist_w_i),
        .taken_i(taken_i),
        .mispredict_i(mispredict_i)
    );

    always #5 clk_i = ~clk_i;

    function automatic int mhash(int idx, int g);
        return (idx ^ g) & 15;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int hr, hw, rd, upd, old_ghr;
        if (reset_i) begin
            m_sweep = 0; m_ready = 0; m_ghr = 0;
            m_pv = 0; m_p = 0; m_gh = 0;
            return;
        end
        if (!m_ready) begin
            m_cnt[m_sweep] = 1;
            m_sweep++;
            if (m_sweep == 16) m_ready = 1;
            m_pv = 0; m_p = 0; m_gh = 0;
            return;
        end
        hr = mhash(int'(idx_r_i), m_ghr);
        hw = mhash(int'(idx_w_i), int'(ghist_w_i));
        upd = m_cnt[hw];
        if (taken_i) upd = (upd == 3) ? 3 : upd + 1;
        else         upd = (upd == 0) ? 0 : upd - 1;
        rd = m_cnt[hr];
`ifdef BP_FE_BP_GHIST_BYPASS_EN
        if (w_v_i && hw == hr) rd = upd;
`endif
        if (w_v_i) m_cnt[hw] = upd;
        old_ghr = m_ghr;
        if (w_v_i && mispredict_i)
            m_ghr = ((int'(ghist_w_i) << 1) | int'(taken_i)) & 15;
        else if (m_pv)
            m_ghr = ((m_ghr << 1) | int'(m_p)) & 15;
        m_pv = r_v_i && !(w_v_i && mispredict_i);
        m_p  = (rd >= 2);
        m_gh = old_ghr;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        r_v_i = 0; idx_r_i = 0; w_v_i = 0; idx_w_i = 0;
        ghist_w_i = 0; taken_i = 0; mispredict_i = 0;
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1;
        tick();
        reset_i = 0;
        repeat (16) tick();
    endtask

    task automatic wr(input int idx, input int g, input bit t, input bit mis);
        w_v_i = 1; idx_w_i = 4'(idx); ghist_w_i = 4'(g);
        taken_i = t; mispredict_i = mis;
        tick();
        idle();
    endtask

    task automatic rd(input int idx);
        r_v_i = 1; idx_r_i = 4'(idx);
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset_i = 1;
        tick(); tick();
        n_tests++;
        if ({init_done_o, predict_v_o, predict_o, ghist_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 0",
                     {init_done_o, predict_v_o, predict_o, ghist_o});
        end
        reset_i = 0;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (init_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL init_low cycle %0d: got %b want 0", i, init_done_o);
            end
            tick();
        end
        n_tests++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL init_done: got %b want 1", init_done_o);
        end
        rd(5);
        n_tests++;
        if ({predict_v_o, predict_o, ghist_o} !== 6'b10_0000) begin
            n_fail++;
            $display("FAIL first_read: got v%b p%b g%h want v1 p0 g0",
                     predict_v_o, predict_o, ghist_o);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        wr(3, 0, 1, 0);
        wr(3, 0, 1, 0);
        rd(3);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_taken: got v%b p%b want v1 p1", predict_v_o, predict_o);
        end
        wr(3, 0, 1, 0);
        wr(3, 0, 1, 0);
        wr(3, 0, 1, 0);
        wr(3, 0, 0, 1);
        rd(3);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b1 || ghist_o !== 4'h0) begin
            n_fail++;
            $display("FAIL sat_decay1: got v%b p%b g%h want v1 p1 g0",
                     predict_v_o, predict_o, ghist_o);
        end
        wr(3, 0, 0, 1);
        rd(3);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_decay2: got v%b p%b want v1 p0", predict_v_o, predict_o);
        end
    endtask

    task automatic test_repair();
        do_reset();
        wr(11, 0, 1, 0);
        wr(11, 0, 1, 0);
        wr(0, 5, 1, 1);
        rd(0);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b1 || ghist_o !== 4'hb) begin
            n_fail++;
            $display("FAIL repair: got v%b p%b g%h want v1 p1 gb",
                     predict_v_o, predict_o, ghist_o);
        end
    endtask

    task automatic test_squash();
        do_reset();
        r_v_i = 1; idx_r_i = 0;
        w_v_i = 1; idx_w_i = 0; ghist_w_i = 4'h3; taken_i = 0; mispredict_i = 1;
        tick();
        idle();
        n_tests++;
        if (predict_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL squash_v: got %b want 0", predict_v_o);
        end
        rd(0);
        n_tests++;
        if (predict_v_o !== 1'b1 || ghist_o !== 4'h6) begin
            n_fail++;
            $display("FAIL squash_ghr: got v%b g%h want v1 g6", predict_v_o, ghist_o);
        end
    endtask

    task automatic test_collision();
        bit want;
`ifdef BP_FE_BP_GHIST_BYPASS_EN
        want = 1;
`else
        want = 0;
`endif
        do_reset();
        r_v_i = 1; idx_r_i = 2;
        w_v_i = 1; idx_w_i = 2; ghist_w_i = 0; taken_i = 1; mispredict_i = 0;
        tick();
        idle();
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== want) begin
            n_fail++;
            $display("FAIL collision: got v%b p%b want v1 p%b", predict_v_o, predict_o, want);
        end
        rd(2);
        n_tests++;
        if (predict_o !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_after: got %b want 1", predict_o);
        end
    endtask

    task automatic test_reset_midsweep();
        do_reset();
        wr(3, 0, 1, 0);
        wr(3, 0, 1, 0);
        reset_i = 1;
        tick();
        reset_i = 0;
        repeat (7) tick();
        r_v_i = 1; idx_r_i = 1;
        reset_i = 1;
        tick();
        reset_i = 0;
        idle();
        n_tests++;
        if (predict_v_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_pv: got %b want 0", predict_v_o);
        end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (init_done_o !== 1'b0) begin
                n_fail++;
                $display("FAIL midsweep_init cycle %0d: got %b want 0", i, init_done_o);
            end
            tick();
        end
        n_tests++;
        if (init_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL midsweep_done: got %b want 1", init_done_o);
        end
        rd(3);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_entry3: got v%b p%b want v1 p0", predict_v_o, predict_o);
        end
        rd(6);
        n_tests++;
        if (predict_v_o !== 1'b1 || predict_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midsweep_entry6: got v%b p%b want v1 p0", predict_v_o, predict_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset_i      = ($urandom_range(0, 199) == 0);
            r_v_i        = ($urandom_range(0, 3) != 0);
            idx_r_i      = 4'($urandom);
            w_v_i        = $urandom_range(0, 1);
            idx_w_i      = 4'($urandom);
            ghist_w_i    = 4'($urandom);
            taken_i      = $urandom_range(0, 1);
            mispredict_i = ($urandom_range(0, 5) == 0);
            tick();
            n_tests++;
            if (init_done_o !== m_ready || predict_v_o !== m_pv ||
                (m_pv && (predict_o !== m_p || ghist_o !== 4'(m_gh)))) begin
                n_fail++;
                $display("FAIL random cycle %0d: got d%b v%b p%b g%h want d%b v%b p%b g%h",
                         i, init_done_o, predict_v_o, predict_o, ghist_o,
                         m_ready, m_pv, m_p, 4'(m_gh));
            end
        end
        idle();
        reset_i = 0;
    endtask

    initial begin
        idle();
        reset_i = 1;
        for (int i = 0; i < 16; i++) m_cnt[i] = 0;
        m_sweep = 0; m_ready = 0; m_ghr = 0; m_pv = 0; m_p = 0; m_gh = 0;
        test_reset();
        test_saturation();
        test_repair();
        test_squash();
        test_collision();
        test_reset_midsweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_ghist.md
# bp_fe_bp_ghist

Parametrised global-history branch direction predictor for the front end. It is the successor to the static/bimodal wrapper. It holds a speculative global history register (GHR) and a table of saturating counters. The table is indexed by a gshare (XOR) or gselect (concatenation) hash of the PC-derived index and the history. It adds a reset-time table initialisation sweep and mispredict-driven history repair. It sits in bp_fe between the PC generator (read side) and the backend branch resolution path (write side).

## Interface
- bht_idx_width_p, 9: table index width; table holds 2**bht_idx_width_p counters.
- bp_cnt_sat_bits_p, 2: counter width; must be ≥ 2.
- ghist_width_p, 8: GHR width; 1 ≤ ghist_width_p ≤ bht_idx_width_p.
- hash_mode_p, 0: hash selection.
  - 0 = gshare: hash = idx ^ zero-extended ghist.
  - 1 = gselect: hash = {ghist, idx[bht_idx_width_p-ghist_width_p-1:0]}.

- clk_i  in  1  clock; all state updates on the rising edge.
- reset_i  in  1  synchronous, active-high reset.
- init_done_o  out  1  high once the table sweep has completed.
- r_v_i  in  1  prediction request.
- idx_r_i  in  bht_idx_width_p  PC-derived read index.
- predict_v_o  out  1  prediction valid, one cycle after an accepted request.
- predict_o  out  1  predicted direction, 1 = taken (counter MSB).
- ghist_o  out  ghist_width_p  GHR value used by this prediction; the backend returns it on resolution.
- w_v_i  in  1  branch resolution valid.
- idx_w_i  in  bht_idx_width_p  resolved branch index.
- ghist_w_i  in  ghist_width_p  GHR snapshot returned with the branch.
- taken_i  in  1  resolved direction.
- mispredict_i  in  1  resolution was mispredicted; qualified by w_v_i.

## Operation
- The FSM has two states, INIT and READY.
- Reset behaviour:
  - reset_i forces INIT, sets the sweep pointer to 0 and the GHR to 0.
  - All outputs reset to 0: init_done_o, predict_v_o, predict_o, ghist_o.
- INIT state:
  - Writes weakly-not-taken (2**(bp_cnt_sat_bits_p-1) - 1, i.e. 01 for 2 bits) to one entry per cycle.
  - After the entry at pointer 2**bht_idx_width_p - 1 is written, the FSM goes to READY and init_done_o rises.
  - r_v_i and w_v_i are ignored in INIT.
- READY, read path:
  - r_v_i accepts a request every cycle; there is no stall.
  - Hash is computed from idx_r_i and the current GHR.
  - The counter is registered, as is the GHR used; predict_v_o=1 in the next cycle.
- READY, speculative history:
  - On the edge closing a cycle with predict_v_o=1 and no restore: GHR <= {GHR[ghist_width_p-2:0], predict_o}.
  - For ghist_width_p = 1: GHR <= predict_o.
- READY, update path:
  - When w_v_i=1, the counter at hash(idx_w_i, ghist_w_i) saturates toward taken_i.
  - Increment stops at all-ones; decrement stops at 0.
- READY, repair:
  - When w_v_i & mispredict_i, GHR <= {ghist_w_i[ghist_width_p-2:0], taken_i}.
  - Repair overrides any speculative shift in the same cycle.
  - It also squashes a request accepted that same cycle: predict_v_o=0 next cycle.
- Read/write collision on the same hashed index in the same cycle: the read returns the pre-update counter (see Configuration).
- Reset mid-operation, including mid-sweep: the sweep restarts at entry 0 and any pending prediction is dropped.

## Timing
- Read latency: 1 cycle from r_v_i to predict_v_o/predict_o/ghist_o. Outputs hold their values only for that cycle.
- Update latency: the counter write is visible to reads accepted in the cycle after w_v_i.
- Repair latency: the GHR is repaired at the end of the mispredict cycle. A request accepted in the next cycle uses the repaired GHR.
- History lag: back-to-back requests hash with a GHR that does not yet include the immediately preceding prediction. This one-deep lag is intentional.
- INIT duration: exactly 2**bht_idx_width_p cycles after reset_i deasserts. init_done_o rises in the following cycle.

## Configuration
- BP_FE_BP_GHIST_BYPASS_EN:
  - When defined, a same-cycle read/write to the same hashed index returns the post-update counter value.
  - When undefined, the read returns the pre-update value.
  - No other behaviour changes.

## Test plan
Settings: bht_idx_width_p=4, ghist_width_p=4, hash_mode_p=0, 2-bit counters.
- Reset, then idle: init_done_o=0 for 16 cycles then 1. Read idx 5: predict_v_o=1, predict_o=0, ghist_o=0.
- Saturation and decay: 2× w_v_i idx 3, ghist_w 0, taken → read idx 3 gives predict 1. 3 more taken, then 1 not-taken → counter 10, predict 1. One more not-taken → counter 01, predict 0.
- Repair: w_v_i+mispredict_i, ghist_w_i=0101, taken_i=1 → next read idx 0 returns ghist_o=1011 and hits entry 11. Verify by pre-training entry 11 taken.
- Same-cycle squash: r_v_i with w_v_i+mispredict_i → predict_v_o=0 next cycle, GHR equals the repaired value.
- Collision: entry 2 at 01, same-cycle taken write and read of idx 2 (GHR 0) → predict_o=0 without the macro, 1 with BP_FE_BP_GHIST_BYPASS_EN.
- Reset mid-sweep: pulse reset_i at sweep cycle 7 → init_done_o stays 0 for a full 16 further cycles. Entries written before the reset still read 01.
